// File: rtl/th_driver_if.sv
// th_driver_if: stimulus/response bus between th_driver and the th-class module under test.
// The master drives the stimulus arrays; the slave side returns the response arrays.
interface th_driver_if;
   logic [14:0] ifl_o;
   logic        kbe_o;
   logic [2:0]  norbhub_i;
   logic [17:0] lr_i;

   modport master (output ifl_o, output kbe_o, input norbhub_i, input lr_i);
   modport slave  (input ifl_o, input kbe_o, output norbhub_i, output lr_i);
endinterface

// File: rtl/th_driver.sv
// th_driver: Galois-LFSR stimulus generator and MISR response compactor for th-class test modules.
// Defining TH_DRIVER_ABORT_EN adds an abort input that ends a run early without a done pulse.
module th_driver #(
   parameter int unsigned NUM_VECS = 16,
   parameter logic [31:0] SEED     = 32'hACE1_5EED
) (
   input  logic        clk,
   input  logic        rst_n,
   input  logic        start,
   input  logic [31:0] seed,
`ifdef TH_DRIVER_ABORT_EN
   input  logic        abort,
`endif
   output logic        busy,
   output logic        done,
   output logic [31:0] signature,
   output logic [31:0] seed_after,
   th_driver_if.master bus
);
   typedef enum logic [1:0] {IDLE, RUN, DRAIN, DONE} state_t;

   localparam logic [15:0] LAST = 16'(NUM_VECS - 1);

   state_t      state_q, state_d;
   logic [31:0] lfsr_q, lfsr_d;
   logic [31:0] sig_q, sig_d;
   logic [31:0] sa_q, sa_d;
   logic [31:0] nxt;
   logic [15:0] cnt_q, cnt_d;
   logic [14:0] ifl_q, ifl_d;
   logic        kbe_q, kbe_d;

   function automatic logic [31:0] lfsr_step(input logic [31:0] x);
      return (x >> 1) ^ (x[0] ? 32'h8020_0003 : 32'h0);
   endfunction

   function automatic logic [31:0] misr_fold(input logic [31:0] s, input logic [17:0] lr,
                                             input logic [2:0] nb);
      return {s[30:0], s[31]} ^ {11'b0, lr, nb};
   endfunction

   always_comb begin
      state_d = state_q;
      lfsr_d  = lfsr_q;
      sig_d   = sig_q;
      sa_d    = sa_q;
      cnt_d   = cnt_q;
      ifl_d   = ifl_q;
      kbe_d   = kbe_q;
      nxt     = lfsr_step(lfsr_q);
      busy    = (state_q == RUN) || (state_q == DRAIN);
      done    = 1'b0;
      case (state_q)
         IDLE: begin
            if (start) begin
               state_d = RUN;
               lfsr_d  = (seed == 32'h0) ? SEED : seed;
               cnt_d   = 16'h0;
               sig_d   = 32'h0;
            end
         end
         RUN: begin
            lfsr_d = nxt;
            ifl_d  = nxt[14:0];
            kbe_d  = nxt[15];
            cnt_d  = cnt_q + 16'h1;
            // The first RUN edge has no response to fold yet; the DUT answers one edge later.
            if (cnt_q != 16'h0) sig_d = misr_fold(sig_q, bus.lr_i, bus.norbhub_i);
            if (cnt_q == LAST) state_d = DRAIN;
         end
         DRAIN: begin
            sig_d   = misr_fold(sig_q, bus.lr_i, bus.norbhub_i);
            ifl_d   = 15'h0;
            kbe_d   = 1'b0;
            sa_d    = lfsr_q;
            state_d = DONE;
         end
         DONE: begin
            done    = 1'b1;
            state_d = IDLE;
         end
         default: state_d = IDLE;
      endcase
`ifdef TH_DRIVER_ABORT_EN
      // Abort keeps the partial signature and records where the LFSR stopped.
      if (busy && abort) begin
         state_d = IDLE;
         lfsr_d  = lfsr_q;
         cnt_d   = cnt_q;
         sig_d   = sig_q;
         sa_d    = lfsr_q;
         ifl_d   = 15'h0;
         kbe_d   = 1'b0;
      end
`endif
   end

   always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n) begin
         state_q <= IDLE;
         lfsr_q  <= 32'h0;
         sig_q   <= 32'h0;
         sa_q    <= 32'h0;
         cnt_q   <= 16'h0;
         ifl_q   <= 15'h0;
         kbe_q   <= 1'b0;
      end else begin
         state_q <= state_d;
         lfsr_q  <= lfsr_d;
         sig_q   <= sig_d;
         sa_q    <= sa_d;
         cnt_q   <= cnt_d;
         ifl_q   <= ifl_d;
         kbe_q   <= kbe_d;
      end
   end

   assign signature  = sig_q;
   assign seed_after = sa_q;
   assign bus.ifl_o  = ifl_q;
   assign bus.kbe_o  = kbe_q;
endmodule

// File: tb/tb_th_driver.sv
// tb_th_driver: directed table-driven bench for th_driver with three run lengths (1, 2, 16).
// The response side is either a constant or a combinational function of the current stimulus.
module tb_th_driver;
   logic clk = 1'b0;
   logic rst_n;
   logic [2:0]        start_r, abort_r, mode_r, busy_w, done_w, kbe_w;
   logic [2:0][31:0]  seed_r, sig_w, sa_w;
   logic [2:0][2:0]   nb_r;
   logic [2:0][17:0]  lr_r;
   logic [2:0][14:0]  ifl_w;
   int n_cmp = 0;
   int n_bad = 0;

   always #5 clk = ~clk;

   genvar g;
   for (g = 0; g < 3; g++) begin : g_dut
      localparam int NVG = (g == 0) ? 1 : (g == 1) ? 2 : 16;
      th_driver_if bus ();
      th_driver #(.NUM_VECS(NVG), .SEED(32'hACE1_5EED)) u_dut (
         .clk(clk), .rst_n(rst_n), .start(start_r[g]), .seed(seed_r[g]),
`ifdef TH_DRIVER_ABORT_EN
         .abort(abort_r[g]),
`endif
         .busy(busy_w[g]), .done(done_w[g]), .signature(sig_w[g]), .seed_after(sa_w[g]),
         .bus(bus)
      );
      assign bus.norbhub_i = mode_r[g] ? (bus.ifl_o[2:0] ^ bus.ifl_o[14:12]) : nb_r[g];
      assign bus.lr_i      = mode_r[g] ? {bus.ifl_o, bus.kbe_o, bus.ifl_o[1:0]} : lr_r[g];
      assign ifl_w[g] = bus.ifl_o;
      assign kbe_w[g] = bus.kbe_o;
   end

   typedef struct {
      int          inst;
      logic [31:0] seed;
      logic        md;
      logic [2:0]  nb;
      logic [17:0] lr;
      logic [14:0] ifl1;
      logic        kbe1;
      logic        use_model;
      logic [31:0] sa;
      logic [31:0] sig;
   } vec_t;
   vec_t tbl[5];

   function automatic int nv_of(input int k);
      return (k == 0) ? 1 : (k == 1) ? 2 : 16;
   endfunction

   function automatic void model(input logic [31:0] s, input int nstep, input int nfold,
                                 input logic md, input logic [2:0] nb, input logic [17:0] lr,
                                 output logic [31:0] sa, output logic [31:0] sig);
      logic [31:0] x;
      logic [20:0] r;
      x   = (s == 32'h0) ? 32'hACE1_5EED : s;
      sig = 32'h0;
      for (int i = 1; i <= nstep; i++) begin
         x = (x >> 1) ^ (x[0] ? 32'h8020_0003 : 32'h0);
         r = md ? {x[14:0], x[15], x[1:0], x[2:0] ^ x[14:12]} : {lr, nb};
         if (i <= nfold) sig = {sig[30:0], sig[31]} ^ {11'b0, r};
      end
      sa = x;
   endfunction

   task automatic chk(input string nm, input logic [31:0] act, input logic [31:0] exp);
      n_cmp++;
      if (act !== exp) begin
         n_bad++;
         $display("FAIL %s: got %0h want %0h", nm, act, exp);
      end
   endtask

   task automatic run_row(input vec_t v);
      int k, n, c;
      logic [31:0] esa, esig;
      k = v.inst;
      n = nv_of(k);
      if (v.use_model) model(v.seed, n, n, v.md, v.nb, v.lr, esa, esig);
      else begin
         esa  = v.sa;
         esig = v.sig;
      end
      @(negedge clk);
      mode_r[k] = v.md; nb_r[k] = v.nb; lr_r[k] = v.lr; seed_r[k] = v.seed;
      start_r[k] = 1'b1;
      @(posedge clk); #1;
      start_r[k] = 1'b0;
      chk("busy_after_start", 32'(busy_w[k]), 32'h1);
      chk("sig_zero_busy", sig_w[k], 32'h0);
      @(posedge clk); #1;
      chk("first_ifl", 32'(ifl_w[k]), 32'(v.ifl1));
      chk("first_kbe", 32'(kbe_w[k]), 32'(v.kbe1));
      c = 1;
      while (done_w[k] !== 1'b1 && c < 200) begin
         @(posedge clk); #1;
         c++;
      end
      chk("done_edge", 32'(c), 32'(n + 1));
      chk("busy_in_done", 32'(busy_w[k]), 32'h0);
      chk("ifl_cleared", 32'(ifl_w[k]), 32'h0);
      chk("signature", sig_w[k], esig);
      chk("seed_after", sa_w[k], esa);
      @(posedge clk); #1;
      chk("done_one_cycle", 32'(done_w[k]), 32'h0);
      chk("sig_hold", sig_w[k], esig);
   endtask

   initial begin
      logic [31:0] esa, esig;
      int ndone, cd, c;
      rst_n = 1'b0;
      start_r = '0; abort_r = '0; mode_r = '0; seed_r = '0; nb_r = '0; lr_r = '0;
      tbl[0] = '{0, 32'h1, 1'b0, 3'b000, 18'h0, 15'h0003, 1'b0, 1'b0, 32'h8020_0003, 32'h0};
      tbl[1] = '{1, 32'h1, 1'b0, 3'b001, 18'h0, 15'h0003, 1'b0, 1'b0, 32'hC030_0002, 32'h3};
      tbl[2] = '{1, 32'h1, 1'b0, 3'b000, 18'h1, 15'h0003, 1'b0, 1'b0, 32'hC030_0002, 32'h18};
      tbl[3] = '{2, 32'h0, 1'b1, 3'b000, 18'h0, 15'h2F75, 1'b1, 1'b1, 32'h0, 32'h0};
      tbl[4] = '{2, 32'h1234_5678, 1'b1, 3'b000, 18'h0, 15'h2B3C, 1'b0, 1'b1, 32'h0, 32'h0};

      repeat (3) @(posedge clk);
      #1;
      for (int k = 0; k < 3; k++) begin
         chk("rst_busy", 32'(busy_w[k]), 32'h0);
         chk("rst_done", 32'(done_w[k]), 32'h0);
         chk("rst_sig", sig_w[k], 32'h0);
         chk("rst_sa", sa_w[k], 32'h0);
         chk("rst_ifl", 32'({kbe_w[k], ifl_w[k]}), 32'h0);
      end
      @(negedge clk) rst_n = 1'b1;
      repeat (2) @(posedge clk);
      #1 chk("idle_busy", 32'(busy_w), 32'h0);

      for (int i = 0; i < 5; i++) run_row(tbl[i]);

      // Start pulsed in RUN and held in DONE: neither may restart the run.
      @(negedge clk);
      mode_r[2] = 1'b1; seed_r[2] = 32'h5; start_r[2] = 1'b1;
      @(posedge clk); #1;
      start_r[2] = 1'b0; seed_r[2] = 32'hDEAD_BEEF;
      model(32'h5, 16, 16, 1'b1, 3'b0, 18'h0, esa, esig);
      ndone = 0; cd = 0;
      for (int i = 1; i <= 20; i++) begin
         @(posedge clk); #1;
         if (i == 3) start_r[2] = 1'b1;
         if (i == 4) start_r[2] = 1'b0;
         if (done_w[2]) begin
            ndone++; cd = i;
            chk("ign_sig", sig_w[2], esig);
            chk("ign_sa", sa_w[2], esa);
            start_r[2] = 1'b1;
         end else if (cd != 0 && i == cd + 1) begin
            chk("ign_start_in_done", 32'(busy_w[2]), 32'h0);
            start_r[2] = 1'b0;
         end
      end
      chk("ign_done_count", 32'(ndone), 32'h1);
      chk("ign_run_len", 32'(cd), 32'd17);

      // Start held high throughout: restart lands N+3 edges after the first accept.
      @(negedge clk);
      seed_r[2] = 32'h7; start_r[2] = 1'b1;
      model(32'h7, 16, 16, 1'b1, 3'b0, 18'h0, esa, esig);
      @(posedge clk); #1;
      c = 0;
      while (done_w[2] !== 1'b1 && c < 40) begin
         @(posedge clk); #1;
         c++;
      end
      chk("b2b_done_edge", 32'(c), 32'd17);
      chk("b2b_sig", sig_w[2], esig);
      @(posedge clk); #1 chk("b2b_idle", 32'(busy_w[2]), 32'h0);
      @(posedge clk); #1 chk("b2b_restart", 32'(busy_w[2]), 32'h1);
      start_r[2] = 1'b0;
      repeat (5) @(posedge clk);
      #2 rst_n = 1'b0;
      #1;
      chk("mid_rst_busy", 32'(busy_w[2]), 32'h0);
      chk("mid_rst_ifl", 32'({kbe_w[2], ifl_w[2]}), 32'h0);
      chk("mid_rst_sig", sig_w[2], 32'h0);
      chk("mid_rst_sa", sa_w[2], 32'h0);
      ndone = 0;
      for (int i = 0; i < 6; i++) begin
         if (i == 3) @(negedge clk) rst_n = 1'b1;
         @(posedge clk); #1;
         if (done_w[2]) ndone++;
      end
      chk("mid_rst_no_done", 32'(ndone), 32'h0);

`ifdef TH_DRIVER_ABORT_EN
      @(negedge clk);
      seed_r[2] = 32'h9; start_r[2] = 1'b1;
      @(posedge clk); #1;
      start_r[2] = 1'b0;
      repeat (5) @(posedge clk);
      #1 abort_r[2] = 1'b1;
      @(posedge clk); #1;
      abort_r[2] = 1'b0;
      model(32'h9, 5, 4, 1'b1, 3'b0, 18'h0, esa, esig);
      chk("abort_busy", 32'(busy_w[2]), 32'h0);
      chk("abort_ifl", 32'({kbe_w[2], ifl_w[2]}), 32'h0);
      chk("abort_sig", sig_w[2], esig);
      chk("abort_sa", sa_w[2], esa);
      ndone = 0;
      for (int i = 0; i < 4; i++) begin
         if (done_w[2]) ndone++;
         @(posedge clk); #1;
      end
      chk("abort_no_done", 32'(ndone), 32'h0);
`endif

      $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
      $finish;
   end
endmodule
